// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the switch debouncer slice.
//   irq_state_t        : IRQ FSM state encoding (IDLE=0, PENDING=1)
//   DEF_*              : default timing constants (1 ms tick @ 50 MHz, 10 ms stable)
package switch_debouncer_pkg;

   typedef enum logic {
      IRQ_IDLE    = 1'b0,
      IRQ_PENDING = 1'b1
   } irq_state_t;

   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_TICK_DIV     = 50000;
   localparam int DEF_STABLE_TICKS = 10;

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch channel: synchroniser chain, stable-level counter, debounced
// output flop and one-cycle change pulse.
//   CLK, RST : clock, synchronous active-high reset
//   tick     : prescaler strobe from the top level
//   raw      : asynchronous switch pin
//   value    : debounced level (registered)
//   changed  : one-cycle pulse when value takes a new level
module debounce_bit #(
   parameter int SYNC_STAGES  = 2,
   parameter int STABLE_TICKS = 10
) (
   input  logic CLK,
   input  logic RST,
   input  logic tick,
   input  logic raw,
   output logic value,
   output logic changed
);

   localparam int CW = $clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic                   sync;

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q  <= '0;
         cnt     <= '0;
         value   <= 1'b0;
         changed <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
         changed <= 1'b0;
         // Agreement with the current level always wins, so a bounce back
         // throws away whatever progress the new level had made.
         if (sync == value) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt == LAST) begin
               value   <= sync;
               cnt     <= '0;
               changed <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: per-bit synchronise + debounce, plus a level
// interrupt raised on any accepted change and cleared by processor ACK.
//   CLK, RST        : clock, synchronous active-high reset
//   SWITCH_RAW      : asynchronous switch pins
//   SWITCH_VALUE    : debounced switch levels
//   SWITCH_CHANGED  : per-bit one-cycle pulse on an accepted change
//   IRQ_RAISE       : interrupt request, held until acknowledged
//   IRQ_ACK         : one-cycle acknowledge from the processor
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] SWITCH_RAW,
   output logic [WIDTH-1:0] SWITCH_VALUE,
   output logic [WIDTH-1:0] SWITCH_CHANGED,
   output logic             IRQ_RAISE,
   input  logic             IRQ_ACK
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic          any_chg;
   irq_state_t    state;

   // With TICK_DIV=1 the counter sits at 0 and tick is high every cycle.
   assign tick = (pre_cnt == PW'(TICK_DIV - 1));

   always_ff @(posedge CLK) begin
      if (RST || tick) pre_cnt <= '0;
      else             pre_cnt <= pre_cnt + PW'(1);
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_TICKS (STABLE_TICKS)
      ) u_bit (
         .CLK     (CLK),
         .RST     (RST),
         .tick    (tick),
         .raw     (SWITCH_RAW[i]),
         .value   (SWITCH_VALUE[i]),
         .changed (SWITCH_CHANGED[i])
      );
   end

   assign any_chg = |SWITCH_CHANGED;

   // IRQ_RAISE is loaded with the next-state decode so it tracks state
   // without an extra cycle of lag. An ACK that coincides with a fresh
   // change keeps the request up so that change is not lost.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IRQ_IDLE;
         IRQ_RAISE <= 1'b0;
      end else begin
         case (state)
            IRQ_IDLE: begin
               if (any_chg) begin
                  state     <= IRQ_PENDING;
                  IRQ_RAISE <= 1'b1;
               end
            end
            IRQ_PENDING: begin
               if (IRQ_ACK && !any_chg) begin
                  state     <= IRQ_IDLE;
                  IRQ_RAISE <= 1'b0;
               end
            end
            default: begin
               state     <= IRQ_IDLE;
               IRQ_RAISE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (TICK_DIV=4, STABLE_TICKS=3,
// SYNC_STAGES=2 -> acceptance 11..14 cycles after a raw step).
module tb_switch_debouncer;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] SWITCH_RAW;
   logic [7:0] SWITCH_VALUE;
   logic [7:0] SWITCH_CHANGED;
   logic       IRQ_RAISE;
   logic       IRQ_ACK;

   always #5 CLK = ~CLK;

   switch_debouncer #(
      .WIDTH        (8),
      .SYNC_STAGES  (2),
      .TICK_DIV     (4),
      .STABLE_TICKS (3)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .SWITCH_RAW     (SWITCH_RAW),
      .SWITCH_VALUE   (SWITCH_VALUE),
      .SWITCH_CHANGED (SWITCH_CHANGED),
      .IRQ_RAISE      (IRQ_RAISE),
      .IRQ_ACK        (IRQ_ACK)
   );

   typedef struct {
      logic [7:0] val;
      logic [7:0] chg;
   } exp_t;

   typedef struct {
      logic [7:0] raw;
      logic [7:0] val;
      logic [7:0] chg;
   } vec_t;

   localparam int LAT_MIN = 11;
   localparam int LAT_MAX = 14;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Drive a raw pattern, record the expected acceptance, then wait for the
   // change pulse and check it against the scoreboard head.
   task automatic run_step(input string name, input logic [7:0] raw, input exp_t e,
                           input bit bounce0, input bit ack_on_chg);
      logic [7:0] prev;
      int         lat;
      bit         seen;
      bit         glitch;
      exp_t       want;
      prev   = SWITCH_VALUE;
      lat    = 0;
      seen   = 0;
      glitch = 0;
      SWITCH_RAW = raw;
      sbq.push_back(e);
      while (!seen && lat < 40) begin
         cyc();
         lat++;
         if (SWITCH_CHANGED != 8'h00) seen = 1;
         else if (SWITCH_VALUE !== prev) glitch = 1;
         if (bounce0 && !seen && (lat % 2 == 0)) SWITCH_RAW[0] = ~SWITCH_RAW[0];
      end
      SWITCH_RAW[0] = raw[0];
      want = sbq.pop_front();
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s timeout: no change pulse in %0d cycles, want %0h", name, lat, want.chg);
      end else begin
         chk({name, " value"}, 32'(SWITCH_VALUE), 32'(want.val));
         chk({name, " changed"}, 32'(SWITCH_CHANGED), 32'(want.chg));
         chk({name, " no-intermediate"}, 32'(glitch), 32'd0);
         n_cmp++;
         if (lat < LAT_MIN || lat > LAT_MAX) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d..%0d", name, lat, LAT_MIN, LAT_MAX);
         end
         if (ack_on_chg) IRQ_ACK = 1'b1;
         cyc();
         IRQ_ACK = 1'b0;
         chk({name, " pulse-width"}, 32'(SWITCH_CHANGED), 32'd0);
         chk({name, " irq"}, 32'(IRQ_RAISE), 32'd1);
      end
   endtask

   task automatic pulse_ack(input string name);
      IRQ_ACK = 1'b1;
      cyc();
      IRQ_ACK = 1'b0;
      chk({name, " irq after ack"}, 32'(IRQ_RAISE), 32'd0);
   endtask

   initial begin
      vec_t vecs[5];
      bit   bad_v;
      bit   bad_c;
      bit   bad_i;
      vecs[0] = '{raw: 8'h00, val: 8'h00, chg: 8'hFF};
      vecs[1] = '{raw: 8'h05, val: 8'h05, chg: 8'h05};
      vecs[2] = '{raw: 8'hA5, val: 8'hA5, chg: 8'hA0};
      vecs[3] = '{raw: 8'h5A, val: 8'h5A, chg: 8'hFF};
      vecs[4] = '{raw: 8'h00, val: 8'h00, chg: 8'h5A};

      RST        = 1'b1;
      IRQ_ACK    = 1'b0;
      SWITCH_RAW = 8'hFF;

      // 1. reset with all pins high, then first acceptance
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("reset outputs", {15'd0, SWITCH_VALUE, SWITCH_CHANGED, IRQ_RAISE}, 32'd0);
      end
      RST = 1'b0;
      run_step("reset-ff", 8'hFF, '{val: 8'hFF, chg: 8'hFF}, 0, 0);
      pulse_ack("reset-ff");

      // 2. table of steps, each acknowledged
      for (int i = 0; i < 5; i++) begin
         run_step($sformatf("vec%0d", i), vecs[i].raw, '{val: vecs[i].val, chg: vecs[i].chg}, 0, 0);
         pulse_ack($sformatf("vec%0d", i));
      end

      // 3. bit0 bounce shorter than the stable window
      bad_v = 0; bad_c = 0; bad_i = 0;
      for (int c = 0; c < 60; c++) begin
         if (c < 40 && (c % 3 == 0)) SWITCH_RAW[0] = ~SWITCH_RAW[0];
         if (c == 40) SWITCH_RAW = 8'h00;
         cyc();
         if (SWITCH_VALUE !== 8'h00) bad_v = 1;
         if (SWITCH_CHANGED !== 8'h00) bad_c = 1;
         if (IRQ_RAISE !== 1'b0) bad_i = 1;
      end
      chk("bounce value stuck", 32'(bad_v), 32'd0);
      chk("bounce changed quiet", 32'(bad_c), 32'd0);
      chk("bounce irq quiet", 32'(bad_i), 32'd0);

      // 4. ACK coincident with a change keeps the request pending
      run_step("ack-a", 8'h01, '{val: 8'h01, chg: 8'h01}, 0, 0);
      run_step("ack-coinc", 8'h03, '{val: 8'h03, chg: 8'h02}, 0, 1);
      pulse_ack("ack-after-coinc");
      run_step("ack-back", 8'h00, '{val: 8'h00, chg: 8'h03}, 0, 0);
      pulse_ack("ack-back");

      // 5. reset in the middle of a count
      SWITCH_RAW = 8'h08;
      bad_c = 0;
      for (int c = 0; c < 6; c++) begin
         cyc();
         if (SWITCH_CHANGED !== 8'h00) bad_c = 1;
      end
      RST = 1'b1;
      cyc();
      chk("midcount reset outputs", {15'd0, SWITCH_VALUE, SWITCH_CHANGED, IRQ_RAISE}, 32'd0);
      RST = 1'b0;
      chk("midcount no early pulse", 32'(bad_c), 32'd0);
      run_step("midcount", 8'h08, '{val: 8'h08, chg: 8'h08}, 0, 0);
      pulse_ack("midcount");

      // 6. bit7 steady high while bit0 bounces
      run_step("bit7-vs-bit0", 8'h88, '{val: 8'h88, chg: 8'h80}, 1, 0);
      pulse_ack("bit7-vs-bit0");
      bad_c = 0;
      for (int c = 0; c < 20; c++) begin
         cyc();
         if (SWITCH_CHANGED !== 8'h00) bad_c = 1;
      end
      chk("bit0 untouched", 32'(SWITCH_VALUE), 32'h88);
      chk("bit0 no late pulse", 32'(bad_c), 32'd0);

      chk("scoreboard drained", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
